// File: rtl/line_ram_pipe_if.sv
// Request/response bundle for line_ram_pipe.
//   master: drives reqRead, reqWrite, reqAddr, wrData, wrMask, parInj;
//           receives rdData, rdRdy, rdErr, wrAck, parErr.
//   slave : the memory side (mirror of master).
interface line_ram_pipe_if #(
  parameter int unsigned LINE_W = 512,
  parameter int unsigned WORD_W = 32
);
  localparam int unsigned WORDS = LINE_W / WORD_W;

  logic              reqRead;
  logic              reqWrite;
  logic [31:0]       reqAddr;
  logic [LINE_W-1:0] wrData;
  logic [WORDS-1:0]  wrMask;
  logic              parInj;
  logic [LINE_W-1:0] rdData;
  logic              rdRdy;
  logic              rdErr;
  logic              wrAck;
  logic [WORDS-1:0]  parErr;

  modport master (
    output reqRead, reqWrite, reqAddr, wrData, wrMask, parInj,
    input  rdData, rdRdy, rdErr, wrAck, parErr
  );

  modport slave (
    input  reqRead, reqWrite, reqAddr, wrData, wrMask, parInj,
    output rdData, rdRdy, rdErr, wrAck, parErr
  );
endinterface

// File: rtl/line_ram_pipe.sv
// Word-masked line memory with pipelined read latency.
//   clk   : sole clock, rising edge.
//   rst_n : synchronous active-low reset (clears pipeline/outputs, not the array).
//   bus   : line_ram_pipe_if.slave - request inputs, read/ack/error outputs.
// Optional feature: define LINE_RAM_PARITY_EN for per-word even parity
// storage and checking; otherwise parInj is ignored and parErr is 0.
// The array is exposed as `mem` (indexed by line) for image loading.
module line_ram_pipe #(
  parameter int unsigned LINE_W      = 512,
  parameter int unsigned WORD_W      = 32,
  parameter int unsigned LINE_AB     = 11,
  parameter int unsigned LATENCY     = 1,
  parameter int unsigned WRITE_FIRST = 0
) (
  input logic           clk,
  input logic           rst_n,
  line_ram_pipe_if.slave bus
);
  localparam int unsigned WORDS   = LINE_W / WORD_W;
  localparam int unsigned ADDR_LO = $clog2(LINE_W / 8);
  localparam int unsigned DEPTH   = 1 << LINE_AB;

  logic [LINE_W-1:0] mem [DEPTH];

  logic [LINE_AB-1:0] lineIdx;
  logic               inRange;
  logic [LINE_W-1:0]  oldLine;
  logic [LINE_W-1:0]  s0Data;
  logic [WORDS-1:0]   s0Par;
  logic               s0Err;
  logic               unusedAddrLo;

  assign lineIdx      = bus.reqAddr[ADDR_LO +: LINE_AB];
  assign inRange      = (bus.reqAddr >> (ADDR_LO + LINE_AB)) == '0;
  assign oldLine      = mem[lineIdx];
  assign unusedAddrLo = ^bus.reqAddr[ADDR_LO-1:0];

`ifdef LINE_RAM_PARITY_EN
  logic [WORDS-1:0] memPar [DEPTH];
  logic [WORDS-1:0] oldPar;
  assign oldPar = memPar[lineIdx];
`else
  logic unusedParInj;
  assign unusedParInj = bus.parInj;
`endif

  // Array write: masked-in words only; out-of-range and reset-edge writes dropped.
  always_ff @(posedge clk) begin
    if (rst_n && bus.reqWrite && inRange) begin
      for (int unsigned i = 0; i < WORDS; i++) begin
        if (bus.wrMask[i]) begin
          mem[lineIdx][i*WORD_W +: WORD_W] <= bus.wrData[i*WORD_W +: WORD_W];
`ifdef LINE_RAM_PARITY_EN
          memPar[lineIdx][i] <= (^bus.wrData[i*WORD_W +: WORD_W]) ^ bus.parInj;
`endif
        end
      end
    end
  end

  // First pipeline input. Request shares one address, so a same-cycle
  // read+write always targets the same line; write-first merges here.
  // A merged word's recomputed parity mismatches exactly when parInj is set.
  always_comb begin
    s0Data = oldLine;
    s0Par  = '0;
    for (int unsigned i = 0; i < WORDS; i++) begin
      if ((WRITE_FIRST != 0) && bus.reqWrite && bus.wrMask[i]) begin
        s0Data[i*WORD_W +: WORD_W] = bus.wrData[i*WORD_W +: WORD_W];
`ifdef LINE_RAM_PARITY_EN
        s0Par[i] = bus.parInj;
      end else begin
        s0Par[i] = (^oldLine[i*WORD_W +: WORD_W]) ^ oldPar[i];
`endif
      end
    end
    if (!inRange) begin
      s0Data = '0;
      s0Par  = '0;
    end
    s0Err = !inRange || (|s0Par);
  end

  logic [LINE_W-1:0] pData [LATENCY];
  logic [WORDS-1:0]  pPar  [LATENCY];
  logic [LATENCY-1:0] pVld;
  logic [LATENCY-1:0] pErr;
  logic               wrAckQ;

  // Error/parity bits are zero whenever a stage is invalid, so they are
  // copied unconditionally; data only moves with a valid line so the
  // output register holds its last value between pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pVld   <= '0;
      pErr   <= '0;
      wrAckQ <= 1'b0;
      for (int unsigned i = 0; i < LATENCY; i++) begin
        pData[i] <= '0;
        pPar[i]  <= '0;
      end
    end else begin
      wrAckQ  <= bus.reqWrite;
      pVld[0] <= bus.reqRead;
      pErr[0] <= bus.reqRead && s0Err;
      pPar[0] <= bus.reqRead ? s0Par : '0;
      if (bus.reqRead) pData[0] <= s0Data;
      for (int unsigned i = 1; i < LATENCY; i++) begin
        pVld[i] <= pVld[i-1];
        pErr[i] <= pErr[i-1];
        pPar[i] <= pPar[i-1];
        if (pVld[i-1]) pData[i] <= pData[i-1];
      end
    end
  end

  assign bus.rdData = pData[LATENCY-1];
  assign bus.rdRdy  = pVld[LATENCY-1];
  assign bus.rdErr  = pErr[LATENCY-1];
  assign bus.parErr = pPar[LATENCY-1];
  assign bus.wrAck  = wrAckQ;
endmodule

// File: tb/tb_line_ram_pipe.sv
module tb_line_ram_pipe;
  localparam int LW = 512;
  localparam int NW = 16;
`ifdef LINE_RAM_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  line_ram_pipe_if ifA ();
  line_ram_pipe_if ifB ();

  line_ram_pipe dutA (.clk(clk), .rst_n(rst_n), .bus(ifA));
  line_ram_pipe #(.LATENCY(3), .WRITE_FIRST(1)) dutB (.clk(clk), .rst_n(rst_n), .bus(ifB));

  typedef struct {
    logic [LW-1:0] data;
    logic          err;
    logic [NW-1:0] par;
    int            due;
  } exp_t;

  typedef struct {
    logic          rd;
    logic          wr;
    logic [31:0]   addr;
    logic [31:0]   fill;
    bit            idxFill;
    logic [NW-1:0] mask;
    logic          inj;
    logic          expAck;
  } vec_t;

  exp_t qA[$];
  exp_t qB[$];
  logic [LW-1:0] model [int];
  logic [NW-1:0] mpar  [int];
  int tests = 0;
  int fails = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [LW-1:0] mkLine(input logic [31:0] fill, input bit idx);
    logic [LW-1:0] l;
    for (int i = 0; i < NW; i++) l[i*32 +: 32] = idx ? 32'(i) : fill;
    return l;
  endfunction

  task automatic checkOut(input int w, input logic [LW-1:0] d, input logic rdy, input logic err,
                          input logic ack, input logic [NW-1:0] pe, input logic expAck, input logic inReset);
    exp_t e;
    bit have;
    string n;
    n = (w == 0) ? "A" : "B";
    chk({n, ".wrAck"}, ack, expAck);
    if (inReset) begin
      if (w == 0) qA.delete(); else qB.delete();
      chk({n, ".rdRdy@rst"}, rdy, 1'b0);
      chk({n, ".rdData@rst"}, d, '0);
      chk({n, ".rdErr@rst"}, err, 1'b0);
      return;
    end
    have = 0;
    if (w == 0 && qA.size() > 0 && qA[0].due == cyc) begin e = qA.pop_front(); have = 1; end
    if (w == 1 && qB.size() > 0 && qB[0].due == cyc) begin e = qB.pop_front(); have = 1; end
    chk({n, ".rdRdy"}, rdy, have);
    if (have) begin
      chk({n, ".rdData"}, d, e.data);
      chk({n, ".rdErr"}, err, e.err);
      chk({n, ".parErr"}, pe, e.par);
    end else begin
      chk({n, ".rdErrIdle"}, err, 1'b0);
      chk({n, ".parErrIdle"}, pe, '0);
    end
  endtask

  task automatic step(input logic rd, input logic wr, input logic [31:0] addr, input logic [LW-1:0] wd,
                      input logic [NW-1:0] mask, input logic inj, input logic rstn, input logic expAck);
    logic oor;
    int line;
    logic [LW-1:0] old, merged;
    logic [NW-1:0] oldp, mergedp;
    exp_t e;
    rst_n = rstn;
    ifA.reqRead = rd;  ifA.reqWrite = wr; ifA.reqAddr = addr; ifA.wrData = wd; ifA.wrMask = mask; ifA.parInj = inj;
    ifB.reqRead = rd;  ifB.reqWrite = wr; ifB.reqAddr = addr; ifB.wrData = wd; ifB.wrMask = mask; ifB.parInj = inj;
    oor  = addr[31:17] != '0;
    line = int'(addr[16:6]);
    old  = model.exists(line) ? model[line] : '0;
    oldp = mpar.exists(line) ? mpar[line] : '0;
    merged = old;
    mergedp = oldp;
    for (int i = 0; i < NW; i++) begin
      if (mask[i]) begin
        merged[i*32 +: 32] = wd[i*32 +: 32];
        mergedp[i] = inj;
      end
    end
    if (rstn && rd) begin
      if (oor) begin
        e = '{data: '0, err: 1'b1, par: '0, due: cyc + 1};
        qA.push_back(e);
        e.due = cyc + 3;
        qB.push_back(e);
      end else begin
        e.data = old;
        e.par  = PAR ? oldp : '0;
        e.err  = |e.par;
        e.due  = cyc + 1;
        qA.push_back(e);
        e.data = wr ? merged : old;
        e.par  = PAR ? (wr ? mergedp : oldp) : '0;
        e.err  = |e.par;
        e.due  = cyc + 3;
        qB.push_back(e);
      end
    end
    if (rstn && wr && !oor) begin
      model[line] = merged;
      mpar[line]  = mergedp;
    end
    @(posedge clk);
    #1;
    cyc++;
    checkOut(0, ifA.rdData, ifA.rdRdy, ifA.rdErr, ifA.wrAck, ifA.parErr, expAck, !rstn);
    checkOut(1, ifB.rdData, ifB.rdRdy, ifB.rdErr, ifB.wrAck, ifB.parErr, expAck, !rstn);
  endtask

  task automatic rd1(input logic [31:0] a);
    step(1'b1, 1'b0, a, '0, '0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0, '0, '0, 1'b0, 1'b1, 1'b0);
  endtask

  vec_t tbl [18];

  initial begin
    tbl[0]  = '{1'b0, 1'b1, 32'h40,      32'h0,        1'b1, 16'hFFFF, 1'b0, 1'b1};
    tbl[1]  = '{1'b1, 1'b0, 32'h40,      32'h0,        1'b0, 16'h0000, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 32'h80,      32'hAAAAAAAA, 1'b0, 16'hFFFF, 1'b0, 1'b1};
    tbl[3]  = '{1'b0, 1'b1, 32'h80,      32'h55555555, 1'b0, 16'h00F0, 1'b0, 1'b1};
    tbl[4]  = '{1'b1, 1'b0, 32'h80,      32'h0,        1'b0, 16'h0000, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 32'h40,      32'h11111111, 1'b0, 16'hFFFF, 1'b0, 1'b1};
    tbl[6]  = '{1'b1, 1'b1, 32'h40,      32'h22222222, 1'b0, 16'hFFFF, 1'b0, 1'b1};
    tbl[7]  = '{1'b1, 1'b0, 32'h40,      32'h0,        1'b0, 16'h0000, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 32'h0,       32'h13579BDF, 1'b0, 16'hFFFF, 1'b0, 1'b1};
    tbl[9]  = '{1'b1, 1'b0, 32'h20000,   32'h0,        1'b0, 16'h0000, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 32'h20000,   32'hDEADBEEF, 1'b0, 16'hFFFF, 1'b0, 1'b1};
    tbl[11] = '{1'b1, 1'b0, 32'h0,       32'h0,        1'b0, 16'h0000, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 1'b1, 32'hC0,      32'h0F0F0F0F, 1'b0, 16'hFFFF, 1'b1, 1'b1};
    tbl[13] = '{1'b1, 1'b0, 32'hC0,      32'h0,        1'b0, 16'h0000, 1'b0, 1'b0};
    tbl[14] = '{1'b0, 1'b1, 32'hC0,      32'h0F0F0F0F, 1'b0, 16'hFFFF, 1'b0, 1'b1};
    tbl[15] = '{1'b1, 1'b0, 32'hC0,      32'h0,        1'b0, 16'h0000, 1'b0, 1'b0};
    tbl[16] = '{1'b0, 1'b1, 32'h80,      32'h0,        1'b0, 16'h0000, 1'b0, 1'b1};
    tbl[17] = '{1'b1, 1'b0, 32'h80,      32'h0,        1'b0, 16'h0000, 1'b0, 1'b0};

    // Reset state.
    step(1'b0, 1'b0, 32'h0, '0, '0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 32'h0, '0, '0, 1'b0, 1'b0, 1'b0);

    foreach (tbl[i])
      step(tbl[i].rd, tbl[i].wr, tbl[i].addr, mkLine(tbl[i].fill, tbl[i].idxFill),
           tbl[i].mask, tbl[i].inj, 1'b1, tbl[i].expAck);
    idle(4);

    // Three reads then reset on the following edge (with a write that must be dropped):
    // anything not yet delivered is discarded.
    rd1(32'h40);
    rd1(32'h80);
    rd1(32'hC0);
    step(1'b0, 1'b1, 32'h40, mkLine(32'hBADBAD00, 1'b0), 16'hFFFF, 1'b0, 1'b0, 1'b0);
    // First edge out of reset accepts a request; the dropped write is not visible.
    rd1(32'h40);
    idle(4);

    // Back-to-back reads, no reset: one result per cycle, in order.
    rd1(32'h40);
    rd1(32'h80);
    rd1(32'hC0);
    idle(5);

    chk("A.drained", 32'(qA.size()), 32'd0);
    chk("B.drained", 32'(qB.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
